// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port byte-writable RAM.
// The owner keeps streaming until MAX_BURST grants, then yields to a waiting peer.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_0,
    input  logic                    req_1,
    input  logic [ADDR_WIDTH-1:0]   addr_0,
    input  logic [ADDR_WIDTH-1:0]   addr_1,
    input  logic [DATA_WIDTH-1:0]   din_0,
    input  logic [DATA_WIDTH-1:0]   din_1,
    input  logic [DATA_WIDTH/8-1:0] we_0,
    input  logic [DATA_WIDTH/8-1:0] we_1,
    output logic                    ack_0,
    output logic                    ack_1,
    output logic                    rd_valid_0,
    output logic                    rd_valid_1,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    output logic [DATA_WIDTH/8-1:0] mem_write_en,
    input  logic [DATA_WIDTH-1:0]   mem_dout
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          rv0_q, rv1_q;
    logic          win_v;
    logic          win;

    // Winner: owner first (with burst limit), otherwise plain round-robin.
    always_comb begin
        win_v = 1'b0;
        win   = 1'b0;
        if (owner_q == OWN0 && req_0) begin
            win_v = 1'b1;
            win   = req_1 && (cnt_q == CNT_TOP);
        end else if (owner_q == OWN1 && req_1) begin
            win_v = 1'b1;
            win   = !(req_0 && (cnt_q == CNT_TOP));
        end else if (req_0 && req_1) begin
            win_v = 1'b1;
            win   = ~last_q;
        end else if (req_0) begin
            win_v = 1'b1;
            win   = 1'b0;
        end else if (req_1) begin
            win_v = 1'b1;
            win   = 1'b1;
        end
        if (reset) begin
            win_v = 1'b0;
        end
    end

    always_comb begin
        ack_0        = win_v & ~win;
        ack_1        = win_v & win;
        mem_addr     = ack_1 ? addr_1 : addr_0;
        mem_din      = ack_1 ? din_1 : din_0;
        mem_write_en = '0;
        if (win_v) begin
            mem_write_en = win ? we_1 : we_0;
        end
    end

    always_comb begin
        owner_d = IDLE;
        cnt_d   = '0;
        last_d  = last_q;
        if (win_v) begin
            owner_d = win ? OWN1 : OWN0;
            last_d  = win;
            if (owner_d == owner_q) begin
                cnt_d = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rv0_q   <= ack_0 && (we_0 == NB'(0));
            rv1_q   <= ack_1 && (we_1 == NB'(0));
        end
    end

    // A read acked just before reset must not show up while reset is high.
    assign rd_valid_0 = rv0_q & ~reset;
    assign rd_valid_1 = rv1_q & ~reset;
    assign rd_data    = mem_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM plus a run-length arbitration model.
// Scenario tasks drive stimulus and compare DUT outputs against the model.
module tb_ram_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int MB = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          req_0, req_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] din_0, din_1;
    logic [NB-1:0] we_0, we_1;
    logic          ack_0, ack_1;
    logic          rd_valid_0, rd_valid_1;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [NB-1:0] mem_write_en;
    logic [DW-1:0] mem_dout;

    ram_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_0       (req_0),
        .req_1       (req_1),
        .addr_0      (addr_0),
        .addr_1      (addr_1),
        .din_0       (din_0),
        .din_1       (din_1),
        .we_0        (we_0),
        .we_1        (we_1),
        .ack_0       (ack_0),
        .ack_1       (ack_1),
        .rd_valid_0  (rd_valid_0),
        .rd_valid_1  (rd_valid_1),
        .rd_data     (rd_data),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_write_en(mem_write_en),
        .mem_dout    (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    function automatic logic [DW-1:0] seed(int i);
        if (i == 32'h20) return 32'h1122_3344;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    // RAM with one-cycle read latency; preloaded while load is high.
    logic          load;
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= seed(i);
        end else begin
            for (int b = 0; b < NB; b++)
                if (mem_write_en[b])
                    ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
        end
        mem_dout <= ram[mem_addr];
    end

    // Reference model: contents, grant history as a run length.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_pg;
    int            m_last;
    int            m_run;
    bit            p_rv0, p_rv1;
    logic [DW-1:0] p_rd;
    int            e_w;
    bit            e_rv0, e_rv1;
    logic [DW-1:0] e_rd;
    logic [NB-1:0] e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;

    function automatic int winner(bit r0, bit r1);
        bit rs [2];
        rs[0] = r0;
        rs[1] = r1;
        if (m_pg && rs[m_last]) begin
            if (rs[1-m_last] && m_run >= MB) return 1 - m_last;
            return m_last;
        end
        if (r0 && r1) return 1 - m_last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_step();
        e_rv0  = p_rv0;
        e_rv1  = p_rv1;
        e_rd   = p_rd;
        e_wen  = '0;
        e_addr = addr_0;
        e_din  = '0;
        p_rv0  = 1'b0;
        p_rv1  = 1'b0;
        if (reset) begin
            e_rv0  = 1'b0;
            e_rv1  = 1'b0;
            e_w    = -1;
            m_pg   = 1'b0;
            m_last = 1;
            m_run  = 0;
        end else begin
            e_w = winner(req_0, req_1);
            if (e_w < 0) begin
                m_pg  = 1'b0;
                m_run = 0;
            end else begin
                m_run  = (m_pg && e_w == m_last) ? m_run + 1 : 1;
                m_pg   = 1'b1;
                m_last = e_w;
                e_addr = (e_w == 1) ? addr_1 : addr_0;
                e_din  = (e_w == 1) ? din_1 : din_0;
                e_wen  = (e_w == 1) ? we_1 : we_0;
                if (e_wen == '0) begin
                    p_rv0 = (e_w == 0);
                    p_rv1 = (e_w == 1);
                    p_rd  = ref_mem[e_addr];
                end else begin
                    for (int b = 0; b < NB; b++)
                        if (e_wen[b])
                            ref_mem[e_addr][b*8 +: 8] = e_din[b*8 +: 8];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_0 = 1'b0;
        req_1 = 1'b0;
        we_0  = '0;
        we_1  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_0 = 1'($urandom);
            req_1 = 1'($urandom);
            we_0  = NB'($urandom);
            we_1  = NB'($urandom);
            @(negedge clk);
            model_step();
            total++;
            if ({ack_0, ack_1} !== 2'b00 || mem_write_en !== '0) begin
                bad++;
                $display("FAIL reset_out cyc=%0d got ack=%b%b wen=%h exp 00/0",
                         i, ack_0, ack_1, mem_write_en);
            end
            total++;
            if ({rd_valid_0, rd_valid_1} !== 2'b00) begin
                bad++;
                $display("FAIL reset_rv cyc=%0d got=%b%b exp=00",
                         i, rd_valid_0, rd_valid_1);
            end
            tick();
            load = 1'b0;
        end
        reset = 1'b0;
        set_idle();
    endtask

    task automatic test_single_read();
        req_0  = 1'b1;
        addr_0 = AW'(32'h010);
        we_0   = '0;
        @(negedge clk);
        model_step();
        total++;
        if (ack_0 !== 1'b1 || ack_1 !== 1'b0 || mem_addr !== AW'(32'h010)) begin
            bad++;
            $display("FAIL single_ack got ack=%b%b addr=%h exp 10/010",
                     ack_0, ack_1, mem_addr);
        end
        tick();
        set_idle();
        @(negedge clk);
        model_step();
        total++;
        if (rd_valid_0 !== 1'b1 || rd_valid_1 !== 1'b0 || rd_data !== seed(16)) begin
            bad++;
            $display("FAIL single_rd got rv=%b%b data=%h exp 10/%h",
                     rd_valid_0, rd_valid_1, rd_data, seed(16));
        end
        tick();
    endtask

    task automatic test_byte_write();
        req_1  = 1'b1;
        addr_1 = AW'(32'h020);
        din_1  = 32'hAABB_CCDD;
        we_1   = 4'b0010;
        @(negedge clk);
        model_step();
        total++;
        if (ack_1 !== 1'b1 || mem_write_en !== 4'b0010 ||
            mem_din !== 32'hAABB_CCDD || mem_addr !== AW'(32'h020)) begin
            bad++;
            $display("FAIL bw_write got ack1=%b wen=%b din=%h addr=%h",
                     ack_1, mem_write_en, mem_din, mem_addr);
        end
        tick();
        set_idle();
        req_0  = 1'b1;
        addr_0 = AW'(32'h020);
        @(negedge clk);
        model_step();
        total++;
        if (ack_0 !== 1'b1 || rd_valid_1 !== 1'b0) begin
            bad++;
            $display("FAIL bw_read got ack0=%b rv1=%b exp 1/0", ack_0, rd_valid_1);
        end
        tick();
        set_idle();
        @(negedge clk);
        model_step();
        total++;
        if (rd_valid_0 !== 1'b1 || rd_data !== 32'h1122_CC44) begin
            bad++;
            $display("FAIL bw_data got rv0=%b data=%h exp 1/1122cc44",
                     rd_valid_0, rd_data);
        end
        tick();
    endtask

    task automatic test_contention();
        int pat [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        reset = 1'b1;
        @(negedge clk);
        model_step();
        tick();
        reset  = 1'b0;
        req_0  = 1'b1;
        req_1  = 1'b1;
        addr_0 = AW'($urandom_range(0, 63));
        addr_1 = AW'($urandom_range(0, 63));
        for (int i = 0; i < 17; i++) begin
            if (i == 16) set_idle();
            @(negedge clk);
            model_step();
            if (i < 16) begin
                total++;
                if (ack_0 !== (pat[i] == 0) || ack_1 !== (pat[i] == 1)) begin
                    bad++;
                    $display("FAIL cont_ack cyc=%0d got=%b%b exp port %0d",
                             i, ack_0, ack_1, pat[i]);
                end
            end
            total++;
            if (rd_valid_0 !== e_rv0 || rd_valid_1 !== e_rv1 ||
                ((e_rv0 || e_rv1) && rd_data !== e_rd)) begin
                bad++;
                $display("FAIL cont_rv cyc=%0d got=%b%b/%h exp=%b%b/%h",
                         i, rd_valid_0, rd_valid_1, rd_data, e_rv0, e_rv1, e_rd);
            end
            tick();
            if (e_w == 0) addr_0 = AW'($urandom_range(0, 63));
            if (e_w == 1) addr_1 = AW'($urandom_range(0, 63));
        end
    endtask

    task automatic test_late_arrival();
        int waited = -1;
        set_idle();
        @(negedge clk);
        model_step();
        tick();
        req_0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            addr_0 = AW'($urandom_range(0, 63));
            @(negedge clk);
            model_step();
            total++;
            if (ack_0 !== 1'b1 || rd_valid_0 !== e_rv0) begin
                bad++;
                $display("FAIL late_stream cyc=%0d got ack0=%b rv0=%b exp 1/%b",
                         i, ack_0, rd_valid_0, e_rv0);
            end
            tick();
        end
        req_1  = 1'b1;
        addr_1 = AW'(32'h030);
        for (int k = 0; k < 8 && waited < 0; k++) begin
            @(negedge clk);
            model_step();
            if (ack_1 === 1'b1) waited = k;
            tick();
            if (e_w == 0) addr_0 = AW'($urandom_range(0, 63));
        end
        req_1 = 1'b0;
        total++;
        if (waited < 0 || waited > MB - 1) begin
            bad++;
            $display("FAIL late_wait got=%0d cycles exp<=%0d", waited, MB - 1);
        end
        @(negedge clk);
        model_step();
        total++;
        if (ack_0 !== 1'b1 || rd_valid_1 !== 1'b1 || rd_data !== seed(48)) begin
            bad++;
            $display("FAIL late_resume got ack0=%b rv1=%b data=%h exp 1/1/%h",
                     ack_0, rd_valid_1, rd_data, seed(48));
        end
        tick();
        set_idle();
        @(negedge clk);
        model_step();
        tick();
    endtask

    task automatic test_reset_mid();
        req_0  = 1'b1;
        addr_0 = AW'(32'h011);
        @(negedge clk);
        model_step();
        total++;
        if (ack_0 !== 1'b1) begin
            bad++;
            $display("FAIL rmid_ack got=%b exp=1", ack_0);
        end
        tick();
        reset  = 1'b1;
        req_1  = 1'b1;
        we_1   = 4'hF;
        addr_1 = AW'(32'h011);
        @(negedge clk);
        model_step();
        total++;
        if ({rd_valid_0, rd_valid_1, ack_0, ack_1} !== 4'b0000 ||
            mem_write_en !== '0) begin
            bad++;
            $display("FAIL rmid_in_reset got rv=%b%b ack=%b%b wen=%h exp 0",
                     rd_valid_0, rd_valid_1, ack_0, ack_1, mem_write_en);
        end
        tick();
        reset = 1'b0;
        we_1  = '0;
        @(negedge clk);
        model_step();
        total++;
        if (ack_0 !== 1'b1 || ack_1 !== 1'b0 || rd_valid_0 !== 1'b0) begin
            bad++;
            $display("FAIL rmid_tie got ack=%b%b rv0=%b exp 10/0",
                     ack_0, ack_1, rd_valid_0);
        end
        tick();
        set_idle();
        @(negedge clk);
        model_step();
        tick();
    endtask

    task automatic test_idle();
        int diffs = 0;
        int errs  = 0;
        set_idle();
        for (int i = 0; i < 100; i++) begin
            addr_0 = AW'($urandom);
            addr_1 = AW'($urandom);
            din_0  = $urandom;
            din_1  = $urandom;
            we_0   = NB'($urandom);
            we_1   = NB'($urandom);
            @(negedge clk);
            model_step();
            if ({ack_0, ack_1} !== 2'b00 || mem_write_en !== '0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL idle_out got %0d busy cycles exp 0", errs);
        end
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== ref_mem[i]) diffs++;
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL idle_ram got %0d differing words exp 0", diffs);
        end
    endtask

    bit            rq [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rdn [2];
    logic [NB-1:0] rw [2];

    task automatic new_txn(int p);
        rq[p]  = ($urandom_range(0, 3) != 0);
        ra[p]  = AW'($urandom_range(0, 31));
        rdn[p] = $urandom;
        rw[p]  = ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0;
    endtask

    task automatic test_random();
        int errs  = 0;
        int diffs = 0;
        new_txn(0);
        new_txn(1);
        for (int i = 0; i < 400; i++) begin
            req_0 = rq[0]; addr_0 = ra[0]; din_0 = rdn[0]; we_0 = rw[0];
            req_1 = rq[1]; addr_1 = ra[1]; din_1 = rdn[1]; we_1 = rw[1];
            @(negedge clk);
            model_step();
            total++;
            if (ack_0 !== (e_w == 0) || ack_1 !== (e_w == 1) ||
                mem_write_en !== e_wen || mem_addr !== e_addr ||
                (e_w >= 0 && mem_din !== e_din)) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_grant cyc=%0d got ack=%b%b wen=%h addr=%h exp w=%0d wen=%h addr=%h",
                             i, ack_0, ack_1, mem_write_en, mem_addr, e_w, e_wen, e_addr);
            end
            total++;
            if (rd_valid_0 !== e_rv0 || rd_valid_1 !== e_rv1 ||
                ((e_rv0 || e_rv1) && rd_data !== e_rd)) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_read cyc=%0d got=%b%b/%h exp=%b%b/%h",
                             i, rd_valid_0, rd_valid_1, rd_data, e_rv0, e_rv1, e_rd);
            end
            tick();
            for (int p = 0; p < 2; p++)
                if (e_w == p || !rq[p]) new_txn(p);
        end
        set_idle();
        @(negedge clk);
        model_step();
        tick();
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== ref_mem[i]) diffs++;
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL rand_ram got %0d differing words exp 0", diffs);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        m_pg   = 1'b0;
        m_last = 1;
        m_run  = 0;
        p_rv0  = 1'b0;
        p_rv1  = 1'b0;
        p_rd   = '0;
        addr_0 = '0;
        addr_1 = '0;
        din_0  = '0;
        din_1  = '0;
        set_idle();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_late_arrival();
        test_reset_mid();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
